// File: rtl/nn_neuron_mac.sv
// nn_neuron_mac -- multiply-accumulate stage for a single neuron.
//
// Accepts N_INPUTS serial (activation, weight) pairs after a start pulse,
// accumulates their signed products, then saturates the sum to 14-bit
// signed and optionally applies ReLU. The result register and the
// saturation flag update only on the edge that accepts the final pair.
// out_valid pulses for one cycle after that edge and is meant to drive the
// enable of a downstream 14-bit result register.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset
//   start     begin an evaluation (honoured only in IDLE)
//   in_valid  x_in/w_in valid this cycle (honoured only in ACC)
//   x_in      signed 8-bit activation
//   w_in      signed 6-bit weight
//   busy      high while in ACC or DONE
//   out_valid one-cycle pulse, result valid
//   result    signed 14-bit saturated (optionally ReLU'd) weighted sum
//   ovf       saturation occurred (meaningful with out_valid)

module nn_neuron_mac #(
  parameter int N_INPUTS = 3,
  parameter bit RELU     = 1'b0,
  parameter int ACC_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic signed [7:0] x_in,
  input  logic signed [5:0] w_in,
  output logic              busy,
  output logic              out_valid,
  output logic signed [13:0] result,
  output logic              ovf
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(8191);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-8192);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         count_q;

  logic signed [13:0]       product;
  logic signed [ACC_W-1:0]  sum;
  logic signed [13:0]       sat_res;
  logic                     sat_ovf;
  logic signed [13:0]       final_res;
  logic                     accept;
  logic                     last_pair;

  // 8x6 signed product always fits in 14 bits, so both operands are
  // sign-extended to 14 bits before multiplying to keep it full precision.
  assign product = $signed({{6{x_in[7]}}, x_in}) * $signed({{8{w_in[5]}}, w_in});

  // The sum includes the incoming product so the final pair can be folded
  // into the result on the same edge it is accepted.
  assign sum = acc_q + ACC_W'(product);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/case leaves it unassigned and infers a latch.
    sat_res = sum[13:0];
    sat_ovf = 1'b0;
    if (sum > SAT_MAX) begin
      sat_res = 14'sd8191;
      sat_ovf = 1'b1;
    end else if (sum < SAT_MIN) begin
      sat_res = -14'sd8192;
      sat_ovf = 1'b1;
    end
    // ReLU acts after saturation; ovf reports the saturation step only.
    final_res = (RELU && sat_res[13]) ? 14'sd0 : sat_res;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_pair = 1'b0;
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        // A pair presented alongside start is deliberately not accumulated.
        if (start) state_d = S_ACC;
      end
      S_ACC: begin
        if (in_valid) begin
          accept    = 1'b1;
          last_pair = (count_q == LAST_IDX);
          if (last_pair) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        acc_q   <= '0;
        count_q <= '0;
      end else if (accept) begin
        acc_q   <= sum;
        count_q <= count_q + 1'b1;
        if (last_pair) begin
          result <= final_res;
          ovf    <= sat_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Testbench for nn_neuron_mac. Two instances share stimulus: one built with
// RELU=0 and one with RELU=1. Expected results are queued when an evaluation
// is issued; a monitor pops and compares whenever either instance pulses
// out_valid.

module tb_nn_neuron_mac;

  logic               clk;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic signed [7:0]  x_in;
  logic signed [5:0]  w_in;

  logic               busy0, out_valid0, ovf0;
  logic signed [13:0] res0;
  logic               busy1, out_valid1, ovf1;
  logic signed [13:0] res1;

  typedef struct {
    logic signed [13:0] res;
    logic               ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  logic signed [13:0] last0, last1;

  nn_neuron_mac #(.N_INPUTS(3), .RELU(1'b0), .ACC_W(16)) dut (
    .Clk(clk), .Rst(rst), .start(start), .in_valid(in_valid),
    .x_in(x_in), .w_in(w_in), .busy(busy0), .out_valid(out_valid0),
    .result(res0), .ovf(ovf0)
  );

  nn_neuron_mac #(.N_INPUTS(3), .RELU(1'b1), .ACC_W(16)) dut_relu (
    .Clk(clk), .Rst(rst), .start(start), .in_valid(in_valid),
    .x_in(x_in), .w_in(w_in), .busy(busy1), .out_valid(out_valid1),
    .result(res1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every out_valid pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid0) begin
      if (q0.size() == 0) check("unexpected out_valid relu0", 1, 0);
      else begin
        e = q0.pop_front();
        check("result relu0", res0, e.res);
        check("ovf relu0", ovf0, e.ovf);
      end
    end
    if (out_valid1) begin
      if (q1.size() == 0) check("unexpected out_valid relu1", 1, 0);
      else begin
        e = q1.pop_front();
        check("result relu1", res1, e.res);
        check("ovf relu1", ovf1, e.ovf);
      end
    end
  end

  // One evaluation: start, three pairs with 'gap' idle cycles between pairs,
  // then the DONE cycle. With poke set, start is also raised with a junk pair
  // in IDLE, during every stall cycle and during DONE; none of it may count.
  task automatic run_eval(input int x0, input int x1, input int x2,
                          input int w0, input int w1, input int w2,
                          input int gap,
                          input int r0, input bit o0,
                          input int r1, input bit o1,
                          input bit poke);
    int xs[3];
    int ws[3];
    exp_t e;
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    e.res = 14'(r0); e.ovf = o0; q0.push_back(e);
    e.res = 14'(r1); e.ovf = o1; q1.push_back(e);

    start = 1'b1;
    if (poke) begin
      in_valid = 1'b1;
      x_in     = 8'(100);
      w_in     = 6'(31);
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check("busy after start", busy0, 1);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x_in     = 8'(xs[i]);
      w_in     = 6'(ws[i]);
      tick();
      in_valid = 1'b0;
      if (i < 2) begin
        check("out_valid early", out_valid0, 0);
        check("result hold relu0", res0, last0);
        check("result hold relu1", res1, last1);
        for (int g = 0; g < gap; g++) begin
          start = poke;
          tick();
          start = 1'b0;
          check("out_valid during stall", out_valid0, 0);
        end
      end
    end
    check("out_valid latency relu0", out_valid0, 1);
    check("out_valid latency relu1", out_valid1, 1);
    start = poke;
    tick();
    start = 1'b0;
    check("out_valid single pulse", out_valid0, 0);
    check("busy drop after done", busy0, 0);
    last0 = 14'(r0);
    last1 = 14'(r1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    w_in     = '0;
    last0    = '0;
    last1    = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", busy0, 0);
    check("reset out_valid", out_valid0, 0);
    check("reset result", res0, 0);
    check("reset ovf", ovf0, 0);
    check("reset result relu1", res1, 0);

    // Basic sum: 10 + 40 + 90.
    run_eval(10, 20, 30, 1, 2, 3, 0, 140, 0, 140, 0, 0);
    // Positive saturation: 3 * 4096 = 12288.
    run_eval(-128, -128, -128, -32, -32, -32, 0, 8191, 1, 8191, 1, 0);
    // Negative saturation: 3 * -4064 = -12192; ReLU then clamps to 0.
    run_eval(127, 127, 127, -32, -32, -32, 0, -8192, 1, 0, 1, 0);
    // Small negative: -15, ReLU gives 0 without ovf.
    run_eval(-5, 0, 0, 3, 0, 0, 0, -15, 0, 0, 0, 0);
    // 20 + 1 + 0, with a junk pair alongside start in IDLE.
    run_eval(4, 1, 0, 5, 1, 7, 0, 21, 0, 21, 0, 1);
    // Stalls of two cycles between pairs, start pulses inside ACC/DONE.
    run_eval(10, 20, 30, 1, 2, 3, 2, 140, 0, 140, 0, 1);

    // Abort an evaluation with reset after one accepted pair.
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    x_in     = 8'(100);
    w_in     = 6'(10);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset busy", busy0, 0);
    check("midreset out_valid", out_valid0, 0);
    check("midreset result", res0, 0);
    check("midreset ovf", ovf0, 0);
    last0 = '0;
    last1 = '0;
    tick();
    check("idle after midreset", busy0, 0);

    // Fresh evaluation with no residue: 1 + 4 + 9.
    run_eval(1, 2, 3, 1, 2, 3, 0, 14, 0, 14, 0, 0);
    // Back-to-back: second start in the IDLE cycle right after DONE.
    run_eval(10, 20, 30, 1, 2, 3, 0, 140, 0, 140, 0, 0);
    run_eval(-1, 2, 5, 1, -3, 5, 0, 18, 0, 18, 0, 0);

    tick();
    tick();
    check("scoreboard drained relu0", q0.size(), 0);
    check("scoreboard drained relu1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
